if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch front end for the pipelined successor of the single-cycle CPU.
//  - Owns the PC and drives a synchronous-read instruction ROM (1-cycle read latency).
//  - Buffers returned words in a 2-entry queue; presents {pc, inst} to decode via valid/ready.
//  - Accepts a one-cycle redirect (jump/branch target) from decode.
// PARAMETERS
//  START_ADDR  32'd0  PC value after reset
//  ROM_AW      5      ROM word-address width; rom_addr = pc[ROM_AW+1:2]
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  resetn       in   1       reset, synchronous, active-low
//  rom_addr     out  ROM_AW  instruction ROM word address
//  rom_inst     in   32      ROM data; valid the cycle after rom_addr is presented
//  redirect     in   1       decode requests PC change this cycle
//  redirect_pc  in   32      new PC; used only when redirect=1
//  id_ready     in   1       decode can accept an instruction this cycle
//  if_valid     out  1       if_pc/if_inst hold a valid instruction
//  if_pc        out  32      PC of head instruction
//  if_inst      out  32      head instruction word
//  fetch_cnt    out  32      instructions delivered to decode (see CONFIGURATION)
//  flush_cnt    out  32      instructions discarded by redirect (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (resetn=0 at posedge):
//    - queue emptied; in-flight flag cleared; req_pc = START_ADDR.
//    - Outputs: if_valid=0, if_pc=0, if_inst=0, counters=0.
//    - rom_addr = START_ADDR[ROM_AW+1:2].
//  - Issue:
//    - rom_addr = req_pc[ROM_AW+1:2], combinationally from req_pc.
//    - A fetch issues in cycle C iff resetn=1, redirect=0, and occ + inflight - pop < 2.
//      occ = queue occupancy (0..2); inflight = fetch issued in C-1 (0/1); pop = if_valid & id_ready.
//    - On issue: req_pc <= req_pc + 4 (32-bit, wraps mod 2^32); inflight <= 1 with rsp_pc = req_pc.
//      ROM index wraps naturally.
//  - Return: in cycle C+1, rom_inst is pushed at end of cycle with rsp_pc.
//    - The issue rule guarantees no overflow; an overflow is a design bug.
//  - Output:
//    - if_valid = (occ != 0); if_pc/if_inst = head entry, registered (no ROM bypass).
//    - Push and pop in the same cycle are both honoured; FIFO order is preserved.
//    - When occ = 0, if_pc/if_inst hold their last values.
//  - Latency / throughput:
//    - First cycle with resetn=1 is C0: addr issued in C0, pushed end of C1.
//    - C2: if_valid=1, if_pc=START_ADDR.
//    - Sustained rate is 1 inst/cycle while id_ready=1.
//    - While id_ready=0, fetch stalls with occ=2 and inflight=0; no word is lost.
//  - Redirect (priority over everything except reset):
//    - Queue cleared; in-flight response discarded (not pushed); req_pc <= redirect_pc.
//    - No issue in the redirect cycle; if_valid=0 next cycle.
//    - A handshake coinciding with redirect is NOT a delivery: no fetch_cnt increment; the head counts as flushed.
//    - First post-redirect inst: addr issued at R+1, pushed end of R+2, if_valid=1 at R+3 with if_pc=redirect_pc.
//    - Back-to-back redirects: the last one wins.
//  - redirect_pc[1:0] is carried into if_pc unchanged; the ROM ignores the low bits.
//  - Reset asserted mid-operation: same as power-on reset at that edge; in-flight data dropped.
// CONFIGURATION
//  Macro IF_PERF_CNT_EN:
//  - Defined:
//    - fetch_cnt += 1 per cycle with if_valid & id_ready & ~redirect.
//    - flush_cnt += occ + (inflight ? 1 : 0) on each redirect cycle.
//    - Both counters 32-bit, wrap mod 2^32, cleared by reset.
//  - Undefined: no counter registers; fetch_cnt and flush_cnt tied to 32'd0.
// TESTING
//  1. Reset 3 cycles, release, id_ready=1 -> if_valid rises at C2; if_pc = 0,4,8,... every cycle; if_inst = ROM[0],ROM[1],...
//  2. Stream, then id_ready=0 for 5 cycles -> occ=2, rom_addr frozen, if_pc constant.
//     - id_ready=1 resumes with no gap, duplicate, or loss.
//  3. Steady stream; redirect=1, redirect_pc=32'h40 in cycle R -> if_valid=0 at R+1..R+2; R+3 if_pc=0x40, if_inst=ROM[16].
//     - With IF_PERF_CNT_EN: flush_cnt=2.
//  4. Redirect coinciding with id_ready & if_valid -> head not counted in fetch_cnt; next delivered pc = redirect_pc.
//  5. Start at PC=0x7C (ROM_AW=5) -> next fetch addr 0x80, rom_addr wraps 31->0; if_pc=0x80, if_inst=ROM[0].
//  6. Assert resetn=0 during stall with occ=2 -> next cycle if_valid=0, counters 0.
//     - After release, the sequence restarts at START_ADDR.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives a 1-cycle synchronous ROM and buffers words in a 2-entry queue toward decode.
// Optional build macro IF_PERF_CNT_EN adds delivered/flushed instruction counters; otherwise both count outputs read 0.
module if_fetch_stage #(
    parameter logic [31:0] START_ADDR = 32'd0,
    parameter int          ROM_AW     = 5
) (
    input  logic              clk,
    input  logic              resetn,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_inst,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       flush_cnt
);

    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    logic        inflight_q, inflight_d;
    logic [1:0]  occ_q, occ_d;
    logic [31:0] pc0_q, pc0_d, inst0_q, inst0_d;
    logic [31:0] pc1_q, pc1_d, inst1_q, inst1_d;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  avail;
    logic [1:0]  wr_slot;

    assign rom_addr = req_pc_q[ROM_AW+1:2];
    assign if_valid = (occ_q != 2'd0);
    assign if_pc    = pc0_q;
    assign if_inst  = inst0_q;

    always_comb begin
        pop     = if_valid & id_ready;
        push    = inflight_q & ~redirect;
        avail   = {1'b0, occ_q} + {2'b00, inflight_q};
        // Only issue when the response is guaranteed a queue slot next cycle.
        issue   = ~redirect & (avail < (3'd2 + {2'b00, pop}));
        wr_slot = occ_q - {1'b0, pop};

        req_pc_d   = req_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = 1'b0;
        occ_d      = occ_q;
        pc0_d      = pc0_q;
        inst0_d    = inst0_q;
        pc1_d      = pc1_q;
        inst1_d    = inst1_q;

        if (redirect) begin
            req_pc_d = redirect_pc;
            occ_d    = 2'd0;
        end else begin
            if (issue) begin
                req_pc_d   = req_pc_q + 32'd4;
                rsp_pc_d   = req_pc_q;
                inflight_d = 1'b1;
            end
            // Slot 0 is the head; it keeps its last contents when the queue drains.
            if (pop && occ_q == 2'd2) begin
                pc0_d   = pc1_q;
                inst0_d = inst1_q;
            end
            if (push) begin
                if (wr_slot == 2'd0) begin
                    pc0_d   = rsp_pc_q;
                    inst0_d = rom_inst;
                end else begin
                    pc1_d   = rsp_pc_q;
                    inst1_d = rom_inst;
                end
            end
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_pc_q   <= START_ADDR;
            rsp_pc_q   <= 32'd0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            pc0_q      <= 32'd0;
            inst0_q    <= 32'd0;
            pc1_q      <= 32'd0;
            inst1_q    <= 32'd0;
        end else begin
            req_pc_q   <= req_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            pc0_q      <= pc0_d;
            inst0_q    <= inst0_d;
            pc1_q      <= pc1_d;
            inst1_q    <= inst1_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            // A handshake in a redirect cycle is a flush, not a delivery.
            if (pop && !redirect) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (redirect) begin
                flush_cnt_q <= flush_cnt_q + {30'd0, occ_q} + {31'd0, inflight_q};
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign fetch_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule
